// File: rtl/mdp3_feed_arbiter.sv
// mdp3_feed_arbiter: shares one MDP3 parser between redundant feed channels A/B.
// Grants whole BEATS-beat messages round-robin, zero-pads stalled messages and
// tags each completion with its channel and a good/bad flag.
module mdp3_feed_arbiter #(
    parameter int unsigned BEATS   = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [63:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [63:0] b_data,
    output logic        b_ready,
    output logic        data_valid,
    output logic [63:0] MESSAGE,
    input  logic        parser_ready,
    input  logic        message_ready,
    output logic        msg_done,
    output logic        msg_channel,
    output logic        msg_bad,
    output logic [15:0] a_msg_count,
    output logic [15:0] b_msg_count,
    output logic [7:0]  abort_count
);

    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_PAD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          bad_q, bad_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          dv_q, dv_d;
    logic [63:0]   msg_q, msg_d;
    logic [15:0]   a_cnt_q, a_cnt_d;
    logic [15:0]   b_cnt_q, b_cnt_d;
    logic [7:0]    abort_q, abort_d;

    logic          sel_valid;
    logic [63:0]   sel_data;

    assign sel_valid = grant_q ? b_valid : a_valid;
    assign sel_data  = grant_q ? b_data  : a_data;

    // Next-state, handshake and completion decode for the grant FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        bad_d        = bad_q;
        beat_d       = beat_q;
        stall_d      = stall_q;
        dv_d         = 1'b0;
        msg_d        = msg_q;
        a_cnt_d      = a_cnt_q;
        b_cnt_d      = b_cnt_q;
        abort_d      = abort_q;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        msg_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (parser_ready && (a_valid || b_valid)) begin
                    grant_d = (a_valid && b_valid) ? ~last_grant_q : b_valid;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                a_ready = ~grant_q;
                b_ready = grant_q;
                if (sel_valid) begin
                    msg_d   = sel_data;
                    dv_d    = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    stall_d = '0;
                    if (beat_q == BEAT_LAST) begin
                        state_d      = S_DONE;
                        last_grant_d = grant_q;
                    end
                end else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_q == STALL_LAST) begin
                        state_d = S_PAD;
                        bad_d   = 1'b1;
                        if (abort_q != '1) begin
                            abort_d = abort_q + 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                dv_d   = 1'b1;
                msg_d  = '0;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (message_ready && parser_ready) begin
                    msg_done = 1'b1;
                    bad_d    = 1'b0;
                    state_d  = S_IDLE;
                    if (!bad_q) begin
                        if (grant_q) begin
                            b_cnt_d = b_cnt_q + 1'b1;
                        end else begin
                            a_cnt_d = a_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            bad_q        <= 1'b0;
            beat_q       <= '0;
            stall_q      <= '0;
            dv_q         <= 1'b0;
            msg_q        <= '0;
            a_cnt_q      <= '0;
            b_cnt_q      <= '0;
            abort_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bad_q        <= bad_d;
            beat_q       <= beat_d;
            stall_q      <= stall_d;
            dv_q         <= dv_d;
            msg_q        <= msg_d;
            a_cnt_q      <= a_cnt_d;
            b_cnt_q      <= b_cnt_d;
            abort_q      <= abort_d;
        end
    end

    assign data_valid  = dv_q;
    assign MESSAGE     = msg_q;
    assign msg_channel = msg_done & grant_q;
    assign msg_bad     = msg_done & bad_q;
    assign a_msg_count = a_cnt_q;
    assign b_msg_count = b_cnt_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_mdp3_feed_arbiter.sv
// Bench for mdp3_feed_arbiter: table of single-message scenarios plus
// hand-written contention, mid-burst reset and abort-saturation sequences.
module tb_mdp3_feed_arbiter;

    localparam int BEATS   = 5;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [63:0] a_data, b_data, MESSAGE;
    logic        data_valid, parser_ready, message_ready;
    logic        msg_done, msg_channel, msg_bad;
    logic [15:0] a_msg_count, b_msg_count;
    logic [7:0]  abort_count;

    always #5 clk = ~clk;

    mdp3_feed_arbiter #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .data_valid(data_valid), .MESSAGE(MESSAGE),
        .parser_ready(parser_ready), .message_ready(message_ready),
        .msg_done(msg_done), .msg_channel(msg_channel), .msg_bad(msg_bad),
        .a_msg_count(a_msg_count), .b_msg_count(b_msg_count),
        .abort_count(abort_count)
    );

    // Parser model: counts beats, raises message_ready a cycle after the last one.
    int   pcnt = 0;
    logic mrdy = 1'b0;
    always @(posedge clk) begin
        if (!reset || msg_done) begin
            pcnt <= 0;
            mrdy <= 1'b0;
        end else if (data_valid) begin
            pcnt <= pcnt + 1;
            if (pcnt == BEATS - 1) mrdy <= 1'b1;
        end
    end
    assign parser_ready  = (pcnt == 0) || mrdy;
    assign message_ready = mrdy;

    // Monitor of the parser bus and completion tags.
    int          cyc = 0;
    logic [63:0] rx[$];
    int          dn_ch[$];
    int          dn_bad[$];
    int          first_dv = -1, last_dv = -1, overlap = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (data_valid) begin
            rx.push_back(MESSAGE);
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
        end
        if (msg_done) begin
            dn_ch.push_back(int'(msg_channel));
            dn_bad.push_back(int'(msg_bad));
        end
        if (a_ready && b_ready) overlap++;
    end

    // Source models.
    logic [63:0] a_q[$], b_q[$];
    int   a_idx = 0, b_idx = 0;
    int   a_gap_at = -1, b_gap_at = -1, a_gap_left = 0, b_gap_left = 0;
    logic a_gapped = 1'b0, b_gapped = 1'b0;

    int total = 0;
    int n_bad = 0;

    typedef struct {
        bit ch;
        int gap_at;
        int gap_len;
        bit exp_bad;
        int exp_span;
        int exp_a;
        int exp_b;
        int exp_ab;
    } vec_t;

    function automatic logic [63:0] beat_val(bit ch, int k);
        return {(ch ? 8'hBB : 8'hAA), 24'(k), 32'h1357_0000 + 32'(k * 7)};
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        a_gapped = (a_idx < a_q.size()) && (a_idx == a_gap_at) && (a_gap_left > 0);
        b_gapped = (b_idx < b_q.size()) && (b_idx == b_gap_at) && (b_gap_left > 0);
        a_valid  = (a_idx < a_q.size()) && !a_gapped;
        b_valid  = (b_idx < b_q.size()) && !b_gapped;
        a_data   = (a_idx < a_q.size()) ? a_q[a_idx] : '0;
        b_data   = (b_idx < b_q.size()) ? b_q[b_idx] : '0;
    endtask

    task automatic step();
        logic aa, ba;
        @(negedge clk);
        aa = a_valid && a_ready;
        ba = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (aa) a_idx++;
        else if (a_gapped) a_gap_left--;
        if (ba) b_idx++;
        else if (b_gapped) b_gap_left--;
        drive();
    endtask

    task automatic clear_mon();
        rx.delete();
        dn_ch.delete();
        dn_bad.delete();
        first_dv = -1;
        last_dv  = -1;
        overlap  = 0;
    endtask

    task automatic drop_sources();
        a_q.delete(); b_q.delete();
        a_idx = 0; b_idx = 0;
        a_gap_at = -1; b_gap_at = -1;
        a_gap_left = 0; b_gap_left = 0;
        drive();
    endtask

    task automatic run_msg(input bit ch, input int base, input int gap_at, input int gap_len,
                           input bit do_chk, input bit exp_bad, input int exp_span);
        int n;
        logic [63:0] expv;
        clear_mon();
        drop_sources();
        for (int i = 0; i < BEATS; i++) begin
            if (ch) b_q.push_back(beat_val(1'b1, base + i));
            else    a_q.push_back(beat_val(1'b0, base + i));
        end
        if (ch) begin b_gap_at = gap_at; b_gap_left = gap_len; end
        else    begin a_gap_at = gap_at; a_gap_left = gap_len; end
        drive();
        n = 0;
        while (dn_ch.size() == 0 && n < 300) begin
            step();
            n++;
        end
        chki("done_count", dn_ch.size(), 1);
        if (do_chk && dn_ch.size() > 0) begin
            chki("msg_channel", dn_ch[0], int'(ch));
            chki("msg_bad", dn_bad[0], int'(exp_bad));
            chki("rx_beats", rx.size(), BEATS);
            for (int i = 0; i < BEATS && i < rx.size(); i++) begin
                expv = (exp_bad && i >= gap_at) ? 64'h0 : beat_val(ch, base + i);
                chk64("beat", rx[i], expv);
            end
            chki("dv_span", last_dv - first_dv + 1, exp_span);
        end
        drop_sources();
    endtask

    task automatic check_reset_outputs();
        chki("rst_data_valid", int'(data_valid), 0);
        chk64("rst_MESSAGE", MESSAGE, 64'h0);
        chki("rst_a_ready", int'(a_ready), 0);
        chki("rst_b_ready", int'(b_ready), 0);
        chki("rst_msg_done", int'(msg_done), 0);
        chki("rst_msg_channel", int'(msg_channel), 0);
        chki("rst_msg_bad", int'(msg_bad), 0);
        chki("rst_a_count", int'(a_msg_count), 0);
        chki("rst_b_count", int'(b_msg_count), 0);
        chki("rst_abort", int'(abort_count), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int n, m, j, c, idx;
        vecs[0] = '{1'b0, -1, 0,      1'b0, 5,  1, 0, 0};
        vecs[1] = '{1'b1, 3,  3,      1'b0, 8,  1, 1, 0};
        vecs[2] = '{1'b0, 2,  100000, 1'b1, 21, 1, 1, 1};
        vecs[3] = '{1'b1, -1, 0,      1'b0, 5,  1, 2, 1};
        vecs[4] = '{1'b0, 4,  15,     1'b0, 20, 2, 2, 1};
        vecs[5] = '{1'b1, 4,  16,     1'b1, 21, 2, 2, 2};

        reset = 1'b0;
        drop_sources();
        step();
        step();
        check_reset_outputs();
        reset = 1'b1;

        // Contention from reset: A wins first, then strict alternation.
        clear_mon();
        for (int i = 0; i < 2 * BEATS; i++) begin
            a_q.push_back(beat_val(1'b0, 100 + i));
            b_q.push_back(beat_val(1'b1, 200 + i));
        end
        drive();
        n = 0;
        while (dn_ch.size() < 4 && n < 400) begin
            step();
            n++;
        end
        chki("cont_done_count", dn_ch.size(), 4);
        for (int k = 0; k < dn_ch.size(); k++) begin
            chki("cont_channel", dn_ch[k], k % 2);
            chki("cont_bad", dn_bad[k], 0);
        end
        chki("cont_rx_beats", rx.size(), 4 * BEATS);
        for (int k = 0; k < rx.size() && k < 4 * BEATS; k++) begin
            m   = k / BEATS;
            j   = k % BEATS;
            c   = m % 2;
            idx = (m / 2) * BEATS + j;
            chk64("cont_beat", rx[k], beat_val(c[0], (c != 0 ? 200 : 100) + idx));
        end
        chki("cont_ready_overlap", overlap, 0);
        chki("cont_a_count", int'(a_msg_count), 2);
        chki("cont_b_count", int'(b_msg_count), 2);
        drop_sources();

        reset = 1'b0;
        step();
        reset = 1'b1;

        // Single-message scenarios.
        for (int i = 0; i < 6; i++) begin
            run_msg(vecs[i].ch, 10 * i, vecs[i].gap_at, vecs[i].gap_len, 1'b1,
                    vecs[i].exp_bad, vecs[i].exp_span);
            chki("vec_a_count", int'(a_msg_count), vecs[i].exp_a);
            chki("vec_b_count", int'(b_msg_count), vecs[i].exp_b);
            chki("vec_abort", int'(abort_count), vecs[i].exp_ab);
        end

        // Reset mid-burst while beat 2 is being offered.
        clear_mon();
        drop_sources();
        for (int i = 0; i < BEATS; i++) a_q.push_back(beat_val(1'b0, 500 + i));
        drive();
        n = 0;
        while (a_idx < 2 && n < 50) begin
            step();
            n++;
        end
        chki("rb_reached_beat2", a_idx, 2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        drop_sources();
        check_reset_outputs();
        repeat (5) step();
        chki("rb_no_tag", dn_ch.size(), 0);
        run_msg(1'b0, 600, -1, 0, 1'b1, 1'b0, BEATS);
        chki("rb_a_count", int'(a_msg_count), 1);
        chki("rb_b_count", int'(b_msg_count), 0);

        // Abort saturation.
        for (int i = 0; i < 256; i++) begin
            run_msg(1'b0, 1000 + i, 1, 100000, 1'b0, 1'b1, 0);
            if (i == 254) chki("abort_reach_255", int'(abort_count), 255);
        end
        chki("abort_saturated", int'(abort_count), 255);
        chki("sat_a_count", int'(a_msg_count), 1);

        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end

endmodule

// File: doc/mdp3_feed_arbiter.md
# mdp3_feed_arbiter

Shares one MDP3 parser between the two redundant CME feed channels (A and B). Grants the parser to one channel for a whole BEATS-beat message, using round-robin on contention. Forwards beats on the parser's data_valid/MESSAGE bus. If a source stalls mid-message, it zero-pads and tags the message bad. On each completion it emits a channel tag for the order book.

## Interface
Parameters:
- BEATS, 5, 64-bit beats per message (≥2)
- TIMEOUT, 16, consecutive stall cycles mid-burst before abort (≥1)

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-low reset
- a_valid  input  1  channel A beat valid
- a_data  input  64  channel A beat
- a_ready  output  1  channel A beat accepted when a_valid & a_ready
- b_valid  input  1  channel B beat valid
- b_data  input  64  channel B beat
- b_ready  output  1  channel B beat accepted when b_valid & b_ready
- data_valid  output  1  to parser, registered
- MESSAGE  output  64  to parser, registered
- parser_ready  input  1  from parser, idle/ready for beat 0
- message_ready  input  1  from parser, level; high once a message is decoded
- msg_done  output  1  one-cycle pulse: parser finished a granted message
- msg_channel  output  1  valid with msg_done; 0=A, 1=B
- msg_bad  output  1  valid with msg_done; message was padded, discard
- a_msg_count  output  16  good messages from A, wraps
- b_msg_count  output  16  good messages from B, wraps
- abort_count  output  8  timeouts, saturates at 255

## Operation
- States:
  - IDLE: waits for parser_ready=1 and at least one channel valid.
  - BURST: forwards the granted channel's beats.
  - PAD: emits zero beats to finish a stalled message.
  - DONE: waits for the parser to report completion.
- Grant selection in IDLE:
  - If only one channel is valid, that channel is granted.
  - If both are valid, the channel not granted last is granted.
  - last_grant resets to B, so A wins the first contention.
  - Grant, beat_cnt=0 and stall_cnt=0 latch on the IDLE→BURST edge.
- BURST:
  - ready of the granted channel is 1 combinationally; the other channel's ready is 0.
  - On an accepted beat: MESSAGE<=data, data_valid<=1, beat_cnt+1, stall_cnt<=0.
  - On a non-accepted cycle: data_valid<=0, stall_cnt+1. The parser holds its beat position.
  - Accepting beat BEATS-1 → DONE, last_grant<=grant.
  - stall_cnt reaching TIMEOUT → PAD, abort_count+1 (saturating), bad<=1.
- PAD:
  - Both readys are 0.
  - Each cycle: data_valid<=1, MESSAGE<=0, beat_cnt+1.
  - Exactly BEATS-beat_cnt zero beats are sent, then → DONE.
- DONE:
  - data_valid<=0; both readys are 0.
  - When message_ready=1 and parser_ready=1:
    - msg_done pulses for one cycle, with msg_channel=grant and msg_bad=bad.
    - If the message was good, the granted channel's counter increments.
    - bad<=0, → IDLE.
- The parser is reset by the same reset; parser_ready=1 is required in IDLE before any grant.
- The non-granted channel is back-pressured (ready=0) for the whole grant; its beats are never dropped.

## Timing
- Reset values: state IDLE, data_valid 0, MESSAGE 0, a_ready/b_ready 0, msg_done/msg_channel/msg_bad 0, all counters 0, last_grant B.
- Reset asserted mid-burst returns to IDLE next cycle. The partial message is neither counted nor tagged.
- The IDLE→BURST decision takes 1 cycle; ready is first high in the cycle after a channel's valid is seen.
- Each accepted beat appears on MESSAGE/data_valid 1 cycle later. A zero-stall message occupies the parser bus for exactly BEATS consecutive cycles.
- msg_done fires in the first DONE cycle in which message_ready=1 and parser_ready=1. This is at least 1 cycle after the last data_valid beat.
- Best-case back-to-back throughput: BEATS+3 cycles per message (grant, BEATS beats, completion, return to IDLE).
- Stall timing:
  - A valid drop that ends before TIMEOUT cycles resumes with no beat loss and no duplication.
  - The transition to PAD happens in the cycle after the stall_cnt==TIMEOUT condition.

## Test plan
- Single A message, 5 beats, valid held high:
  - data_valid high for 5 consecutive cycles; MESSAGE equals a_data beats in order.
  - msg_done with channel 0, bad 0; a_msg_count=1.
- A and B both valid from reset, 2 messages each: grant order A,B,A,B; b_ready stays 0 throughout every A grant; final counts 2/2.
- Message from B with valid dropped 3 cycles after beat 2 (TIMEOUT=16):
  - data_valid low 3 cycles, then beats 3–4 delivered; parser PRICE/QUANTITY correct.
  - msg_bad 0.
- Message from A with valid dropped permanently after beat 1:
  - After 16 stall cycles, 3 zero beats are sent; msg_done with bad 1.
  - abort_count=1 and a_msg_count unchanged; the next B message decodes correctly.
- reset driven low for 1 cycle at beat 2, parser reset together:
  - All outputs at reset values the next cycle.
  - A fresh A message then completes with a_msg_count=1.
- 256 forced timeouts: abort_count saturates at 255.
